lsu_store_buffer: RTL and testbench

Load/store unit that sits directly upstream of `data_memory` and owns its MemRead/MemWrite/addr/write_data/funct3 port. It accepts one memory request per cycle from the execute stage over a valid/ready handshake, checks alignment and funct3 legality, and queues stores in a small FIFO. The FIFO drains lazily in cycles when the memory port is otherwise free. Loads go straight to memory, except when they overlap a queued store, in which case they stall.

---
 rtl/lsu_store_buffer.sv | 130 +++++++++++++
 tb/tb_lsu_store_buffer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_store_buffer.sv
// Load/store front end for data_memory: legality/alignment checks, a small
// store FIFO that drains when the port is free, and load stalls on overlap.
module lsu_store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_write,
  input  logic [31:0]                req_addr,
  input  logic [31:0]                req_wdata,
  input  logic [2:0]                 req_funct3,
  output logic                       rsp_valid,
  output logic [31:0]                rsp_rdata,
  output logic                       rsp_err,
  output logic                       MemRead,
  output logic                       MemWrite,
  output logic [31:0]                mem_addr,
  output logic [31:0]                mem_wdata,
  output logic [2:0]                 mem_funct3,
  input  logic [31:0]                mem_rdata,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  f3;
  } sb_entry_t;

  sb_entry_t         r_fifo [DEPTH];
  logic [PW-1:0]     r_head, r_tail;
  logic [CW-1:0]     r_count;
  logic              r_rsp_valid, r_rsp_err;
  logic [31:0]       r_rsp_rdata;

  logic              w_f3_ok, w_misal, w_err, w_full, w_hazard;
  logic              w_ready, w_accept, w_ld_blocked, w_drain, w_push, w_load;
  logic [DEPTH-1:0]  w_hit;

  always_comb begin
    w_f3_ok = req_write ? (req_funct3 inside {3'b000, 3'b001, 3'b010})
                        : (req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    w_misal = (req_funct3[1:0] == 2'b01 && req_addr[0]) ||
              (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
    w_err   = !w_f3_ok || w_misal;
  end

  assign w_full = (r_count == CW'(DEPTH));

  // Word-granular overlap against every live slot; slot is live if its
  // distance from head is below count.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_haz
    logic [PW-1:0] w_off;
    assign w_off     = PW'(gi) - r_head;
    assign w_hit[gi] = (CW'(w_off) < r_count) &&
                       (r_fifo[gi].addr[31:2] == req_addr[31:2]);
  end
  assign w_hazard = |w_hit;

  always_comb begin
    w_ready = 1'b0;
    if (!rst) begin
      if (w_err)          w_ready = 1'b1;
      else if (req_write) w_ready = !w_full;
      else                w_ready = !w_hazard && !w_full;
    end
  end

  assign w_accept     = req_valid && w_ready;
  assign w_ld_blocked = req_valid && !w_err && !req_write && (w_hazard || w_full);
  assign w_drain      = !rst && (r_count != '0) && (!req_valid || w_full || w_ld_blocked);
  assign w_push       = w_accept && !w_err && req_write;
  assign w_load       = w_accept && !w_err && !req_write;

  always_comb begin
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_funct3 = '0;
    if (w_drain) begin
      MemWrite   = 1'b1;
      mem_addr   = r_fifo[r_head].addr;
      mem_wdata  = r_fifo[r_head].data;
      mem_funct3 = r_fifo[r_head].f3;
    end else if (w_load) begin
      MemRead    = 1'b1;
      mem_addr   = req_addr;
      mem_funct3 = req_funct3;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      if (w_push)  r_tail <= r_tail + 1'b1;
      if (w_drain) r_head <= r_head + 1'b1;
      // push and drain are mutually exclusive: a push needs !full, a drain
      // alongside a valid store needs full
      if (w_push)       r_count <= r_count + 1'b1;
      else if (w_drain) r_count <= r_count - 1'b1;
      r_rsp_valid <= w_accept;
      r_rsp_err   <= w_accept && w_err;
      r_rsp_rdata <= w_load ? mem_rdata : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_tail] <= '{addr: req_addr, data: req_wdata, f3: req_funct3};
  end

  assign req_ready = w_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_rsp_err;
  assign rsp_rdata = r_rsp_rdata;
  assign count     = r_count;
  assign empty     = (r_count == '0);

endmodule

// File: tb/tb_lsu_store_buffer.sv
// Bench for lsu_store_buffer: directed vector table, then random traffic
// against a queue-based model, with a byte-array data_memory behind the DUT.
module tb_lsu_store_buffer;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst, req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_funct3;
  logic        rsp_valid, rsp_err, MemRead, MemWrite, empty;
  logic [31:0] rsp_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  mem_funct3, count;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  lsu_store_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .MemRead(MemRead), .MemWrite(MemWrite), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_funct3(mem_funct3), .mem_rdata(mem_rdata),
    .count(count), .empty(empty)
  );

  // data_memory stand-in: 256 bytes, little endian, combinational read
  logic [7:0] phys_mem [256];
  logic       mem_clr;
  logic [7:0] ra;
  assign ra = mem_addr[7:0];

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) phys_mem[i] <= 8'h00;
    end else if (MemWrite) begin
      phys_mem[ra] <= mem_wdata[7:0];
      if (mem_funct3[1:0] != 2'b00) phys_mem[ra + 8'd1] <= mem_wdata[15:8];
      if (mem_funct3[1:0] == 2'b10) begin
        phys_mem[ra + 8'd2] <= mem_wdata[23:16];
        phys_mem[ra + 8'd3] <= mem_wdata[31:24];
      end
    end
  end

  always_comb begin
    mem_rdata = '0;
    case (mem_funct3)
      3'b000: mem_rdata = {{24{phys_mem[ra][7]}}, phys_mem[ra]};
      3'b001: mem_rdata = {{16{phys_mem[ra + 8'd1][7]}}, phys_mem[ra + 8'd1], phys_mem[ra]};
      3'b010: mem_rdata = {phys_mem[ra + 8'd3], phys_mem[ra + 8'd2], phys_mem[ra + 8'd1], phys_mem[ra]};
      3'b100: mem_rdata = {24'h0, phys_mem[ra]};
      3'b101: mem_rdata = {16'h0, phys_mem[ra + 8'd1], phys_mem[ra]};
      default: mem_rdata = '0;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic        rst, vld, wr;
    logic [31:0] addr, wd;
    logic [2:0]  f3;
    logic        rdy, mrd, mwr;
    logic [31:0] maddr, mwd;
    logic [2:0]  mf3;
    logic [2:0]  cnt;
    logic        rv, rerr;
    logic [31:0] rdata;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, v, w, input logic [31:0] a, d, input logic [2:0] f,
                     input logic rdy, mrd, mwr, input logic [31:0] ma, mw, input logic [2:0] mf,
                     input logic [2:0] c, input logic rv, re, input logic [31:0] rd);
    vec_t t;
    t = '{rst: r, vld: v, wr: w, addr: a, wd: d, f3: f, rdy: rdy, mrd: mrd, mwr: mwr,
          maddr: ma, mwd: mw, mf3: mf, cnt: c, rv: rv, rerr: re, rdata: rd};
    tbl.push_back(t);
  endtask

  // ---------------- reference model ----------------
  typedef struct { logic [31:0] a, d; logic [2:0] f; } st_t;
  st_t        q[$];
  logic [7:0] mmem [256];

  function automatic int nbytes(input logic [2:0] f);
    case (f[1:0])
      2'b01:   return 2;
      2'b10:   return 4;
      default: return 1;
    endcase
  endfunction

  function automatic logic [31:0] mread(input logic [31:0] a, input logic [2:0] f);
    logic [31:0] w;
    w = {mmem[8'(a + 3)], mmem[8'(a + 2)], mmem[8'(a + 1)], mmem[8'(a)]};
    case (f)
      3'b000:  return 32'($signed(w[7:0]));
      3'b001:  return 32'($signed(w[15:0]));
      3'b010:  return w;
      3'b100:  return 32'(w[7:0]);
      3'b101:  return 32'(w[15:0]);
      default: return 32'h0;
    endcase
  endfunction

  task automatic mwrite(input st_t s);
    for (int i = 0; i < nbytes(s.f); i++) mmem[8'(s.a + 32'(i))] = s.d[8*i +: 8];
  endtask

  initial begin
    logic [2:0] f3s [8];
    f3s = '{3'd0, 3'd1, 3'd2, 3'd2, 3'd4, 3'd5, 3'd2, 3'd3};
    for (int i = 0; i < 256; i++) mmem[i] = 8'h00;

    rst = 1'b1; mem_clr = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_funct3 = '0;
    @(posedge clk); @(posedge clk);
    mem_clr = 1'b0;

    //   rst vld wr addr      wdata         f3    rdy mrd mwr maddr     mwdata        mf3   cnt rv err rdata
    add(1, 1, 1, 32'h00, 32'hDEADBEEF, 3'd2,  0, 0, 0, 32'h00, 32'h0,        3'd0, 0, 0, 0, 32'h0);
    add(0, 1, 1, 32'h00, 32'hDEADBEEF, 3'd2,  1, 0, 0, 32'h00, 32'h0,        3'd0, 1, 1, 0, 32'h0);
    add(0, 0, 0, 32'h00, 32'h0,        3'd0,  0, 0, 1, 32'h00, 32'hDEADBEEF, 3'd2, 0, 0, 0, 32'h0);
    add(0, 1, 0, 32'h00, 32'h0,        3'd2,  1, 1, 0, 32'h00, 32'h0,        3'd2, 0, 1, 0, 32'hDEADBEEF);
    for (int i = 0; i < 4; i++)
      add(0, 1, 1, 32'h10 + 32'(4*i), 32'h10 + 32'(4*i), 3'd2, 1, 0, 0, 0, 0, 3'd0, 3'(i + 1), 1, 0, 32'h0);
    add(0, 1, 1, 32'h20, 32'h20,       3'd2,  0, 0, 1, 32'h10, 32'h10,       3'd2, 3, 0, 0, 32'h0);
    add(0, 1, 1, 32'h20, 32'h20,       3'd2,  1, 0, 0, 32'h00, 32'h0,        3'd0, 4, 1, 0, 32'h0);
    for (int i = 0; i < 4; i++)
      add(0, 0, 0, 32'h0, 32'h0, 3'd0, 0, 0, 1, 32'h14 + 32'(4*i), 32'h14 + 32'(4*i), 3'd2, 3'(3 - i), 0, 0, 32'h0);
    add(0, 1, 1, 32'h40, 32'h11223344, 3'd2,  1, 0, 0, 32'h00, 32'h0,        3'd0, 1, 1, 0, 32'h0);
    add(0, 1, 0, 32'h40, 32'h0,        3'd2,  0, 0, 1, 32'h40, 32'h11223344, 3'd2, 0, 0, 0, 32'h0);
    add(0, 1, 0, 32'h40, 32'h0,        3'd2,  1, 1, 0, 32'h40, 32'h0,        3'd2, 0, 1, 0, 32'h11223344);
    add(0, 1, 1, 32'h06, 32'h0000ABCD, 3'd1,  1, 0, 0, 32'h00, 32'h0,        3'd0, 1, 1, 0, 32'h0);
    add(0, 0, 0, 32'h00, 32'h0,        3'd0,  0, 0, 1, 32'h06, 32'h0000ABCD, 3'd1, 0, 0, 0, 32'h0);
    add(0, 1, 0, 32'h06, 32'h0,        3'd1,  1, 1, 0, 32'h06, 32'h0,        3'd1, 0, 1, 0, 32'hFFFFABCD);
    add(0, 1, 0, 32'h06, 32'h0,        3'd5,  1, 1, 0, 32'h06, 32'h0,        3'd5, 0, 1, 0, 32'h0000ABCD);
    add(0, 1, 1, 32'h08, 32'h000000AA, 3'd0,  1, 0, 0, 32'h00, 32'h0,        3'd0, 1, 1, 0, 32'h0);
    add(0, 0, 0, 32'h00, 32'h0,        3'd0,  0, 0, 1, 32'h08, 32'h000000AA, 3'd0, 0, 0, 0, 32'h0);
    add(0, 1, 0, 32'h08, 32'h0,        3'd0,  1, 1, 0, 32'h08, 32'h0,        3'd0, 0, 1, 0, 32'hFFFFFFAA);
    add(0, 1, 0, 32'h08, 32'h0,        3'd4,  1, 1, 0, 32'h08, 32'h0,        3'd4, 0, 1, 0, 32'h000000AA);
    add(0, 1, 1, 32'h30, 32'h5,        3'd2,  1, 0, 0, 32'h00, 32'h0,        3'd0, 1, 1, 0, 32'h0);
    add(0, 1, 0, 32'h02, 32'h0,        3'd2,  1, 0, 0, 32'h00, 32'h0,        3'd0, 1, 1, 1, 32'h0);
    add(0, 1, 1, 32'h05, 32'h1234,     3'd1,  1, 0, 0, 32'h00, 32'h0,        3'd0, 1, 1, 1, 32'h0);
    add(0, 1, 0, 32'h00, 32'h0,        3'd3,  1, 0, 0, 32'h00, 32'h0,        3'd0, 1, 1, 1, 32'h0);
    add(0, 1, 1, 32'h00, 32'h77,       3'd4,  1, 0, 0, 32'h00, 32'h0,        3'd0, 1, 1, 1, 32'h0);
    add(0, 1, 1, 32'h34, 32'h6,        3'd2,  1, 0, 0, 32'h00, 32'h0,        3'd0, 2, 1, 0, 32'h0);
    add(0, 1, 1, 32'h38, 32'h7,        3'd2,  1, 0, 0, 32'h00, 32'h0,        3'd0, 3, 1, 0, 32'h0);
    add(1, 1, 1, 32'h3C, 32'h8,        3'd2,  0, 0, 0, 32'h00, 32'h0,        3'd0, 0, 0, 0, 32'h0);
    add(0, 0, 0, 32'h00, 32'h0,        3'd0,  0, 0, 0, 32'h00, 32'h0,        3'd0, 0, 0, 0, 32'h0);
    add(0, 0, 0, 32'h00, 32'h0,        3'd0,  0, 0, 0, 32'h00, 32'h0,        3'd0, 0, 0, 0, 32'h0);

    foreach (tbl[k]) begin
      vec_t v;
      v = tbl[k];
      @(negedge clk);
      rst = v.rst; req_valid = v.vld; req_write = v.wr;
      req_addr = v.addr; req_wdata = v.wd; req_funct3 = v.f3;
      #4;
      if (v.vld) chk($sformatf("row%0d req_ready", k), 32'(req_ready), 32'(v.rdy));
      chk($sformatf("row%0d MemRead", k),  32'(MemRead),  32'(v.mrd));
      chk($sformatf("row%0d MemWrite", k), 32'(MemWrite), 32'(v.mwr));
      if (v.rst || v.mrd || v.mwr) begin
        chk($sformatf("row%0d mem_addr", k),   mem_addr,         v.maddr);
        chk($sformatf("row%0d mem_funct3", k), 32'(mem_funct3),  32'(v.mf3));
      end
      if (v.rst || v.mwr) chk($sformatf("row%0d mem_wdata", k), mem_wdata, v.mwd);
      @(posedge clk); #1;
      chk($sformatf("row%0d count", k),     32'(count),     32'(v.cnt));
      chk($sformatf("row%0d empty", k),     32'(empty),     32'(v.cnt == 3'd0));
      chk($sformatf("row%0d rsp_valid", k), 32'(rsp_valid), 32'(v.rv));
      if (v.rv || v.rst) begin
        chk($sformatf("row%0d rsp_err", k),   32'(rsp_err), 32'(v.rerr));
        chk($sformatf("row%0d rsp_rdata", k), rsp_rdata,    v.rdata);
      end
    end

    // ---------------- random traffic in 0x80..0x9F ----------------
    @(negedge clk);
    rst = 1'b1; req_valid = 1'b0;
    @(posedge clk); #1;
    q.delete();
    for (int n = 0; n < 3000; n++) begin
      logic        r, v, w, legal, err, full, haz, e_rdy, acc, drain, e_mrd;
      logic [31:0] a, d, e_rd;
      logic [2:0]  f;
      st_t         head;
      r = ($urandom_range(0, 99) == 0);
      v = ($urandom_range(0, 3) != 0);
      w = ($urandom_range(0, 1) == 1);
      a = 32'h80 + 32'(4 * $urandom_range(0, 7)) +
          (($urandom_range(0, 7) == 0) ? 32'($urandom_range(1, 3)) : 32'h0);
      d = $urandom;
      f = f3s[$urandom_range(0, 7)];

      legal = w ? (f inside {3'd0, 3'd1, 3'd2}) : (f inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      err   = !legal || ((a % nbytes(f)) != 0);
      full  = (q.size() == DEPTH);
      haz   = 1'b0;
      foreach (q[i]) if ((q[i].a >> 2) == (a >> 2)) haz = 1'b1;
      e_rdy = err || (w ? !full : (!haz && !full));
      drain = (q.size() > 0) && (!v || full || (!err && !w && !e_rdy));
      if (r) begin e_rdy = 1'b0; drain = 1'b0; end
      acc   = v && e_rdy;
      e_mrd = acc && !err && !w;
      head  = (q.size() > 0) ? q[0] : '{a: 32'h0, d: 32'h0, f: 3'd0};

      @(negedge clk);
      rst = r; req_valid = v; req_write = w; req_addr = a; req_wdata = d; req_funct3 = f;
      #4;
      if (v) chk($sformatf("rnd%0d req_ready", n), 32'(req_ready), 32'(e_rdy));
      chk($sformatf("rnd%0d MemWrite", n), 32'(MemWrite), 32'(drain));
      chk($sformatf("rnd%0d MemRead", n),  32'(MemRead),  32'(e_mrd));
      if (drain) begin
        chk($sformatf("rnd%0d drain addr", n),  mem_addr,        head.a);
        chk($sformatf("rnd%0d drain data", n),  mem_wdata,       head.d);
        chk($sformatf("rnd%0d drain f3", n),    32'(mem_funct3), 32'(head.f));
      end else if (e_mrd) begin
        chk($sformatf("rnd%0d load addr", n),   mem_addr,        a);
        chk($sformatf("rnd%0d load f3", n),     32'(mem_funct3), 32'(f));
      end

      e_rd = e_mrd ? mread(a, f) : 32'h0;
      if (r) q.delete();
      else begin
        if (drain) begin mwrite(q[0]); void'(q.pop_front()); end
        if (acc && !err && w) q.push_back('{a: a, d: d, f: f});
      end

      @(posedge clk); #1;
      chk($sformatf("rnd%0d count", n),     32'(count),     32'(q.size()));
      chk($sformatf("rnd%0d empty", n),     32'(empty),     32'(q.size() == 0));
      chk($sformatf("rnd%0d rsp_valid", n), 32'(rsp_valid), 32'(acc));
      if (acc) begin
        chk($sformatf("rnd%0d rsp_err", n),   32'(rsp_err), 32'(err));
        chk($sformatf("rnd%0d rsp_rdata", n), rsp_rdata,    e_rd);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
